// File: rtl/core_seq_ctrl.sv
// Program-run sequencer: loads instruction memory, runs the core until halt or
// timeout, then stalls the core and streams the data memory out.
module core_seq_ctrl #(
  parameter int unsigned WORD       = 32,
  parameter int unsigned W_OPR      = 32,
  parameter int unsigned ADDR       = 8,
  parameter int unsigned DUMP_WORDS = 256,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             load_valid_i,
  input  logic [WORD-1:0]  load_data_i,
  input  logic             load_last_i,
  output logic             load_ready_o,
  output logic             core_reset_o,
  output logic             core_stall_o,
  input  logic             core_hlt_i,
  input  logic [ADDR-1:0]  core_inst_addr_i,
  input  logic [ADDR-1:0]  core_ldst_addr_i,
  input  logic             core_ldst_write_i,
  output logic [ADDR-1:0]  imem_addr_o,
  output logic [WORD-1:0]  imem_data_o,
  output logic             imem_write_o,
  output logic [ADDR-1:0]  dmem_addr_o,
  output logic             dmem_write_o,
  input  logic [W_OPR-1:0] dmem_q_i,
  output logic             dump_valid_o,
  output logic [ADDR-1:0]  dump_addr_o,
  output logic [W_OPR-1:0] dump_data_o,
  output logic [31:0]      cycle_cnt_o,
  output logic             timeout_o,
  output logic             done_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDump, StDone} state_e;

  // Dump counter is one bit wider so it can reach DUMP_WORDS == DEPTH.
  localparam logic [ADDR:0] DumpEnd   = (ADDR+1)'(DUMP_WORDS);
  localparam logic [31:0]   CycleLast = 32'(MAX_CYCLES - 1);

  state_e          state_q, state_d;
  logic [ADDR-1:0] load_cnt_q, load_cnt_d;
  logic [ADDR:0]   dump_cnt_q, dump_cnt_d;
  logic [31:0]     cycle_cnt_q, cycle_cnt_d;
  logic            timeout_q, timeout_d;
  logic            dump_valid_q, dump_valid_d;
  logic [ADDR-1:0] dump_addr_q, dump_addr_d;

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    dump_cnt_d   = dump_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    timeout_d    = timeout_q;
    dump_valid_d = 1'b0;
    dump_addr_d  = dump_addr_q;
    load_ready_o = 1'b0;
    core_reset_o = 1'b1;
    core_stall_o = 1'b1;
    imem_addr_o  = '0;
    imem_data_o  = '0;
    imem_write_o = 1'b0;
    dmem_addr_o  = '0;
    dmem_write_o = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        core_reset_o = 1'b0;
        if (start_i) begin
          state_d     = StLoad;
          load_cnt_d  = '0;
          cycle_cnt_d = '0;
          timeout_d   = 1'b0;
        end
      end
      StLoad: begin
        core_reset_o = 1'b0;
        load_ready_o = 1'b1;
        imem_addr_o  = load_cnt_q;
        imem_data_o  = load_data_i;
        imem_write_o = load_valid_i;
        if (load_valid_i) begin
          load_cnt_d = load_cnt_q + 1'b1;
          // Top address is the last slot; never wrap over earlier words.
          if (load_last_i || load_cnt_q == '1) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        core_stall_o = 1'b0;
        imem_addr_o  = core_inst_addr_i;
        dmem_addr_o  = core_ldst_addr_i;
        dmem_write_o = core_ldst_write_i;
        dump_cnt_d   = '0;
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (core_hlt_i) begin
          state_d = StDump;
        end else if (cycle_cnt_q == CycleLast) begin
          state_d   = StDump;
          timeout_d = 1'b1;
        end
      end
      StDump: begin
        if (dump_cnt_q < DumpEnd) begin
          dmem_addr_o  = dump_cnt_q[ADDR-1:0];
          dump_valid_d = 1'b1;
          dump_addr_d  = dump_cnt_q[ADDR-1:0];
          dump_cnt_d   = dump_cnt_q + 1'b1;
        end else begin
          // Last beat is on the output this cycle.
          state_d = StDone;
        end
      end
      StDone: begin
        done_o = 1'b1;
        if (start_i) begin
          state_d     = StLoad;
          load_cnt_d  = '0;
          cycle_cnt_d = '0;
          timeout_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      load_cnt_q   <= '0;
      dump_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      timeout_q    <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      dump_cnt_q   <= dump_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      timeout_q    <= timeout_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
    end
  end

  assign dump_valid_o = dump_valid_q;
  assign dump_addr_o  = dump_addr_q;
  assign dump_data_o  = dump_valid_q ? dmem_q_i : '0;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign timeout_o    = timeout_q;

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Sequencer that owns the processor core and its two memories for one program run.
- Holds the core in reset and streams program words into the instruction memory.
- Releases the core and muxes core memory traffic through until halt or timeout, then stalls the core and sweeps the data memory out on a dump stream.
- Sits between top, mem_instruction and mem_data, replacing bench-driven inst_write/reset/stall_i.

Parameters:
- WORD, 32, instruction width
- W_OPR, 32, data memory word width
- ADDR, 8, memory address width; DEPTH = 2**ADDR
- DUMP_WORDS, 256, number of data words dumped (1..DEPTH)
- MAX_CYCLES, 100000, run-cycle limit before forced stop

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- start_i  in  1  begin load/run/dump sequence (level, sampled in IDLE/DONE)
- load_valid_i  in  1  program word valid
- load_data_i  in  WORD  program word
- load_last_i  in  1  final program word marker
- load_ready_o  out  1  program word accepted when valid&ready
- core_reset_o  out  1  active-low reset to top
- core_stall_o  out  1  to top stall_i
- core_hlt_i  in  1  top hlt_o
- core_inst_addr_i  in  ADDR  top inst_addr_o
- core_ldst_addr_i  in  ADDR  top ldst_addr_o
- core_ldst_write_i  in  1  top ldst_write_o
- imem_addr_o / imem_data_o / imem_write_o  out  ADDR / WORD / 1  mem_instruction A, D, W
- dmem_addr_o / dmem_write_o  out  ADDR / 1  mem_data A, W
- dmem_q_i  in  W_OPR  mem_data Q (registered, 1-cycle read latency)
- dump_valid_o / dump_addr_o / dump_data_o  out  1 / ADDR / W_OPR  dump stream, no backpressure
- cycle_cnt_o  out  32  RUN cycles elapsed
- timeout_o / done_o  out  1 / 1  status

Behaviour:
- Reset (reset==0 at posedge): state=IDLE.
  - All counters 0.
  - Every output 0, with core_stall_o=1 and core_reset_o=0.
- Reset mid-operation aborts immediately; partially loaded memory content is left as is.
- States: IDLE, LOAD, RUN, DUMP, DONE.
- IDLE:
  - core_reset_o=0, core_stall_o=1.
  - start_i=1 -> LOAD; load counter=0; cycle_cnt_o=0; timeout_o=0.
- LOAD:
  - load_ready_o=1.
  - On valid&ready: imem_write_o=1, imem_addr_o=load counter, imem_data_o=load_data_i (combinational same cycle); counter+1.
  - Transition -> RUN the cycle after an accepted word with load_last_i=1, or an accepted word at address DEPTH-1.
  - load_ready_o=0 from that cycle on; no wrap, excess words are never accepted.
  - Outside LOAD: imem_write_o=0, load_ready_o=0.
- RUN:
  - core_reset_o=1, core_stall_o=0.
  - imem_addr_o=core_inst_addr_i; dmem_addr_o=core_ldst_addr_i; dmem_write_o=core_ldst_write_i (pure combinational passthrough).
  - cycle_cnt_o increments once per RUN cycle.
  - core_hlt_i=1 -> DUMP.
  - Else if cycle_cnt_o==MAX_CYCLES-1 -> DUMP with timeout_o=1.
  - If both occur in the same cycle, halt wins and timeout_o stays 0.
- DUMP:
  - core_stall_o=1, core_reset_o stays 1 (state preserved for inspection).
  - dmem_write_o=0 unconditionally; core writes are blocked.
  - Dump counter d sweeps 0..DUMP_WORDS-1, one address per cycle on dmem_addr_o.
  - One cycle later: dump_valid_o=1, dump_addr_o=d (delayed), dump_data_o=dmem_q_i.
  - After the valid for address DUMP_WORDS-1 -> DONE.
  - Exactly DUMP_WORDS valid beats, contiguous, ascending.
- DONE:
  - done_o=1 (held); core_stall_o=1; core_reset_o=1.
  - cycle_cnt_o and timeout_o held.
  - start_i=1 -> LOAD: core_reset_o=0, done_o=0, counters cleared.
- start_i is ignored in LOAD/RUN/DUMP.
- cycle_cnt_o saturates at 2^32-1 (unreachable with legal MAX_CYCLES).

Test Plan:
- Reset held 3 cycles, release with start_i=0 -> core_reset_o=0, core_stall_o=1, all other outputs 0, state stays IDLE.
- start_i, 5 words 0x11..0x15 with last on 5th, valid deasserted 1 cycle between words 2 and 3 -> imem writes at addr 0..4 with those data; RUN entered the cycle after word 5; core_reset_o rises then.
- Run program storing 0xA5 to mem[3] then halting at cycle 40 -> dmem passthrough during RUN; DUMP_WORDS=8 yields 8 beats addr 0..7 with beat 3 = 0xA5; done_o=1; timeout_o=0; cycle_cnt_o=40.
- MAX_CYCLES=20, program without halt -> DUMP entered after 20 RUN cycles; timeout_o=1; core_ldst_write_i=1 during DUMP does not reach dmem_write_o.
- Halt asserted on exactly cycle MAX_CYCLES-1 -> timeout_o=0.
- Feed DEPTH+3 words without last -> only DEPTH accepted; load_ready_o low after word DEPTH-1.
- Reset pulled low mid-DUMP -> IDLE next cycle, dump_valid_o=0; subsequent start_i restarts cleanly.
